// File: rtl/rep_chk_pkg.sv
// Shared types for the repetition-sequence checker: operator mode, channel
// FSM state and fail-cause encoding.
package rep_chk_pkg;

  typedef enum logic {
    GOTO   = 1'b0,
    NONCON = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    CHECK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    GOTO_MISS = 2'd1,
    TIMEOUT   = 2'd2,
    ABORT     = 2'd3
  } cause_e;

endpackage

// File: rtl/rep_chk_channel.sv
// One checker channel: attempt FSM with occurrence and timeout counters,
// registered pass/fail pulses, held fail cause and sticky overlap flag.
module rep_chk_channel
  import rep_chk_pkg::*;
#(
  parameter int N_W   = 4,
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             rose,
  input  logic             ev,
  input  logic             mode,
  input  logic [N_W-1:0]   cfg_n,
  input  logic [TMO_W-1:0] cfg_tmo,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output cause_e           cause,
  output logic             overlap
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [N_W-1:0]     n_q, n_d, occ_q, occ_d, occ_inc, n_eff;
  logic [TMO_W-1:0]   lim_q, lim_d, tmo_q, tmo_d, tmo_inc;
  logic               pass_d, fail_d, overlap_d, tmo_hit;
  cause_e             cause_d;

  assign n_eff   = (cfg_n == '0) ? N_W'(1) : cfg_n;
  assign occ_inc = occ_q + N_W'(1);
  assign tmo_inc = tmo_q + TMO_W'(1);
  assign tmo_hit = (lim_q != '0) && (tmo_inc == lim_q);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    lim_d   = lim_q;
    occ_d   = occ_q;
    tmo_d   = tmo_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    cause_d = cause;

    unique case (state_q)
      IDLE: begin
        if (rose && en) begin
          mode_d  = mode ? NONCON : GOTO;
          n_d     = n_eff;
          lim_d   = cfg_tmo;
          tmo_d   = '0;
          // The trigger sample's own ev is occurrence 1 (overlapping form).
          occ_d   = ev ? N_W'(1) : '0;
          state_d = (!mode && ev && n_eff == N_W'(1)) ? CHECK : COUNT;
        end
      end
      COUNT: begin
        tmo_d = tmo_inc;
        if (mode_q == NONCON && ev && occ_q == n_q) begin
          pass_d = 1'b1;
        end else begin
          if (ev) occ_d = occ_inc;
          if (mode_q == GOTO && ev && occ_inc == n_q) state_d = CHECK;
          if (tmo_hit) begin
            fail_d  = 1'b1;
            cause_d = TIMEOUT;
          end
        end
      end
      CHECK: begin
        tmo_d = tmo_inc;
        if (ev) begin
          pass_d = 1'b1;
        end else begin
          fail_d  = 1'b1;
          cause_d = GOTO_MISS;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !en) begin
      pass_d  = 1'b0;
      fail_d  = 1'b1;
      cause_d = ABORT;
    end
    if (pass_d || fail_d) state_d = IDLE;
  end

  // A rise on the deciding sample is dropped silently, not flagged.
  assign overlap_d = overlap | ((state_q != IDLE) && rose && !(pass_d || fail_d));

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= GOTO;
      n_q     <= '0;
      lim_q   <= '0;
      occ_q   <= '0;
      tmo_q   <= '0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      cause   <= NONE;
      overlap <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      lim_q   <= lim_d;
      occ_q   <= occ_d;
      tmo_q   <= tmo_d;
      pass    <= pass_d;
      fail    <= fail_d;
      cause   <= cause_d;
      overlap <= overlap_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: rtl/rep_seq_checker.sv
// Multi-channel ev[->N]/ev[=N] ##1 ev checker: trigger rise detection,
// per-channel FSMs and saturating pass/fail totals.
module rep_seq_checker
  import rep_chk_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int N_W   = 4,
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NCH-1:0]     trig,
  input  logic [NCH-1:0]     ev,
  input  logic [NCH-1:0]     mode,
  input  logic [N_W-1:0]     cfg_n,
  input  logic [TMO_W-1:0]   cfg_tmo,
  output logic [NCH-1:0]     busy,
  output logic [NCH-1:0]     pass,
  output logic [NCH-1:0]     fail,
  output logic [2*NCH-1:0]   cause,
  output logic [NCH-1:0]     overlap,
  output logic [CNT_W-1:0]   pass_total,
  output logic [CNT_W-1:0]   fail_total
);

  localparam int PC_W = $clog2(NCH + 1);

  logic [NCH-1:0]  trig_q, rose;
  logic [PC_W-1:0] pass_cnt, fail_cnt;
  logic [CNT_W:0]  pass_sum, fail_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trig_q <= '0;
    else        trig_q <= trig;
  end

  assign rose = trig & ~trig_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cause_e ch_cause;

    rep_chk_channel #(
      .N_W   (N_W),
      .TMO_W (TMO_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .rose    (rose[i]),
      .ev      (ev[i]),
      .mode    (mode[i]),
      .cfg_n   (cfg_n),
      .cfg_tmo (cfg_tmo),
      .busy    (busy[i]),
      .pass    (pass[i]),
      .fail    (fail[i]),
      .cause   (ch_cause),
      .overlap (overlap[i])
    );

    assign cause[2*i +: 2] = ch_cause;
  end

  always_comb begin
    pass_cnt = '0;
    fail_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      pass_cnt = pass_cnt + PC_W'(pass[i]);
      fail_cnt = fail_cnt + PC_W'(fail[i]);
    end
  end

  // One extra sum bit catches the carry that triggers saturation.
  assign pass_sum = {1'b0, pass_total} + (CNT_W + 1)'(pass_cnt);
  assign fail_sum = {1'b0, fail_total} + (CNT_W + 1)'(fail_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_total <= '0;
      fail_total <= '0;
    end else begin
      pass_total <= pass_sum[CNT_W] ? '1 : pass_sum[CNT_W-1:0];
      fail_total <= fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_rep_seq_checker.sv
// Directed self-checking bench for rep_seq_checker; a second instance with
// 3-bit totals covers saturation.
module tb_rep_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  trig, ev, mode;
  logic [3:0]  cfg_n;
  logic [7:0]  cfg_tmo;

  logic [3:0]  busy, pass, fail, overlap;
  logic [7:0]  cause;
  logic [15:0] pass_total, fail_total;

  logic [3:0]  s_busy, s_pass, s_fail, s_overlap;
  logic [7:0]  s_cause;
  logic [2:0]  s_pass_total, s_fail_total;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rep_seq_checker u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .ev(ev), .mode(mode),
    .cfg_n(cfg_n), .cfg_tmo(cfg_tmo), .busy(busy), .pass(pass), .fail(fail),
    .cause(cause), .overlap(overlap), .pass_total(pass_total),
    .fail_total(fail_total)
  );

  rep_seq_checker #(.CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .trig(trig), .ev(ev), .mode(mode),
    .cfg_n(cfg_n), .cfg_tmo(cfg_tmo), .busy(s_busy), .pass(s_pass),
    .fail(s_fail), .cause(s_cause), .overlap(s_overlap),
    .pass_total(s_pass_total), .fail_total(s_fail_total)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    trig = '0;
    ev   = '0;
    repeat (n) tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; trig = '0; ev = '0; mode = '0;
    cfg_n = 4'd3; cfg_tmo = '0;
    repeat (2) tick();
    check("rst_busy",    busy, 4'h0);
    check("rst_pass",    pass, 4'h0);
    check("rst_cause",   cause, 8'h00);
    check("rst_totals",  {pass_total, fail_total}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Goto miss, N=3: ev on trigger sample plus two more, then absent.
    trig = 4'h1; ev = 4'h1; tick();
    check("miss_busy_rise", busy[0], 1'b1);
    trig = 4'h0; tick(); tick();
    check("miss_no_pass", pass[0], 1'b0);
    ev = 4'h0; tick();
    check("miss_fail",  fail[0], 1'b1);
    check("miss_cause", cause[1:0], 2'd1);
    check("miss_busy_fall", busy[0], 1'b0);
    tick();
    check("miss_fail_total", fail_total, 16'd1);
    check("miss_pass_total", pass_total, 16'd0);
    idle(2);

    // Non-consecutive pass, N=3: idle gap after the third ev, then one more.
    mode = 4'h1;
    trig = 4'h1; ev = 4'h1; tick();
    trig = 4'h0; tick(); tick();
    ev = 4'h0; tick(); tick(); tick();
    check("nc_no_fail", fail[0], 1'b0);
    check("nc_busy",    busy[0], 1'b1);
    ev = 4'h1; tick();
    check("nc_pass",    pass[0], 1'b1);
    check("nc_cause_held", cause[1:0], 2'd1);
    ev = 4'h0; tick();
    check("nc_pass_total", pass_total, 16'd1);
    mode = 4'h0;
    idle(2);

    // Timeout with overlap on ch1: N=4, tmo=5, two ev only, re-rise at cycle 2.
    cfg_n = 4'd4; cfg_tmo = 8'd5;
    trig = 4'h2; ev = 4'h2; tick();
    trig = 4'h0; tick();
    ev = 4'h0; trig = 4'h2; tick();
    check("tmo_overlap", overlap[1], 1'b1);
    trig = 4'h0; tick(); tick();
    check("tmo_not_yet", fail[1], 1'b0);
    tick();
    check("tmo_fail",  fail[1], 1'b1);
    check("tmo_cause", cause[3:2], 2'd2);
    cfg_tmo = '0;
    idle(2);

    // Goto pass, N=2, on ch2; a rise on the deciding sample must not flag overlap.
    cfg_n = 4'd2;
    trig = 4'h4; ev = 4'h4; tick();
    trig = 4'h0; tick();
    check("gp_no_early_pass", pass[2], 1'b0);
    trig = 4'h4; tick();
    check("gp_pass",       pass[2], 1'b1);
    check("gp_no_overlap", overlap[2], 1'b0);
    ev = 4'h0; tick();
    check("gp_rise_dropped", busy[2], 1'b0);
    idle(2);

    // cfg_n = 0 behaves as 1 on ch3.
    cfg_n = 4'd0;
    trig = 4'h8; ev = 4'h8; tick();
    trig = 4'h0; tick();
    check("n0_pass", pass[3], 1'b1);
    idle(2);

    // Abort on ch0 mid-COUNT.
    cfg_n = 4'd3; mode = 4'h1;
    trig = 4'h1; ev = 4'h1; tick();
    trig = 4'h0; ev = 4'h0; en = 1'b0; tick();
    check("abort_fail",  fail[0], 1'b1);
    check("abort_cause", cause[1:0], 2'd3);
    en = 1'b1; mode = 4'h0;
    idle(2);

    // Reset mid-COUNT clears everything at once and emits no pulse.
    trig = 4'h1; ev = 4'h1; tick();
    trig = 4'h0; tick();
    rst_n = 1'b0; #2;
    check("rstm_busy",    busy, 4'h0);
    check("rstm_pulses",  {pass, fail}, 8'h00);
    check("rstm_cause",   cause, 8'h00);
    check("rstm_overlap", overlap, 4'h0);
    check("rstm_totals",  {pass_total, fail_total}, 32'h0);
    ev = '0; tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rstm_quiet", {busy, pass, fail}, 12'h000);

    // All four channels pass together; 3-bit totals saturate at 7.
    cfg_n = 4'd1;
    for (int r = 1; r <= 3; r++) begin
      trig = 4'hF; ev = 4'hF; tick();
      trig = 4'h0; tick();
      check("tot_pass_all", pass, 4'hF);
      ev = 4'h0; tick();
      check("tot_main", pass_total, 16'(4 * r));
      check("tot_sat",  s_pass_total, (r == 1) ? 3'd4 : 3'd7);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
